// File: rtl/count_arbiter.sv
// count_arbiter: two-requester round-robin arbiter that lends a shared 0..TERM counter to the winner
//
// Configuration: define CNT_PAUSE_EN to add the pause input (freezes an active run).
// Ports:
//   clk   - rising-edge clock
//   RST   - asynchronous active-low reset
//   req   - level requests, bit i from requester i
//   pause - freeze request during a run (only with CNT_PAUSE_EN)
//   gnt   - one-hot grant to the current owner of the counter
//   count - shared counter, loads 0 on grant, stops at TERM
//   busy  - a run or its completion cycle is in progress
//   done  - one-cycle completion pulse to the granted requester
module count_arbiter #(
   parameter int WIDTH = 4,
   parameter int TERM  = 9
) (
   input  logic             clk,
   input  logic             RST,
   input  logic [1:0]       req,
`ifdef CNT_PAUSE_EN
   input  logic             pause,
`endif
   output logic [1:0]       gnt,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic [1:0]       done
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [WIDTH-1:0] TERM_C = WIDTH'(TERM);
   logic [1:0] state;
   logic       last;
   logic       win;
   logic       hold;
   logic       lost;
`ifdef CNT_PAUSE_EN
   assign hold = pause;
`else
   assign hold = 1'b0;
`endif
   // last is the requester granted most recently; reset value 1 favours requester 0
   assign win  = req[1] & (~req[0] | ~last);
   assign lost = ~|(req & gnt);
   assign busy = state != IDLE;
   assign done = state == DONE ? gnt : 2'b00;
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
         gnt   <= 2'b00;
         count <= '0;
         last  <= 1'b1;
      end else begin
         case (state)
            IDLE: if (|req) begin
               state <= RUN;
               gnt   <= win ? 2'b10 : 2'b01;
               count <= '0;
            end
            // an owner dropping its request aborts the run, even while paused or at TERM
            RUN: if (lost) begin
               state <= IDLE;
               gnt   <= 2'b00;
               last  <= gnt[1];
            end else if (!hold) begin
               if (count == TERM_C) state <= DONE;
               else count <= count + WIDTH'(1);
            end
            DONE: begin
               state <= IDLE;
               gnt   <= 2'b00;
               last  <= gnt[1];
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_count_arbiter.sv
// tb_count_arbiter: directed and random stimulus against a run-length model of the arbiter
module tb_count_arbiter;
   localparam int TERM = 9;
   logic       clk = 1'b0;
   logic       RST = 1'b1;
   logic [1:0] req = 2'b00;
   logic       pause = 1'b0;
   logic [1:0] gnt;
   logic [3:0] count;
   logic       busy;
   logic [1:0] done;
   int vectors = 0;
   int miscompares = 0;
   int owner = -1;
   int age = 0;
   int cnt_m = 0;
   int last_m = 1;
   int dones = 0;
   count_arbiter #(.WIDTH(4), .TERM(TERM)) dut (
      .clk(clk), .RST(RST), .req(req),
`ifdef CNT_PAUSE_EN
      .pause(pause),
`endif
      .gnt(gnt), .count(count), .busy(busy), .done(done)
   );
   always #5 clk = ~clk;
   // age = edges since grant: 1..TERM counting, TERM+1 is the done cycle
   function automatic void model_edge(input logic [1:0] r, input logic p);
      if (owner < 0) begin
         if (r != 2'b00) begin
            owner = r == 2'b11 ? (last_m == 0 ? 1 : 0) : (r == 2'b01 ? 0 : 1);
            age = 0;
            cnt_m = 0;
         end
      end else if (age == TERM + 1) begin
         last_m = owner;
         owner = -1;
      end else if (!r[owner]) begin
         last_m = owner;
         owner = -1;
      end else if (!p) begin
         age++;
         cnt_m = age < TERM ? age : TERM;
      end
   endfunction
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask
   task automatic check_all(input string tag);
      logic [7:0] eg;
      eg = owner < 0 ? 8'd0 : (owner == 0 ? 8'd1 : 8'd2);
      chk({tag, ".gnt"}, {6'd0, gnt}, eg);
      chk({tag, ".count"}, {4'd0, count}, 8'(cnt_m));
      chk({tag, ".busy"}, {7'd0, busy}, {7'd0, owner >= 0});
      chk({tag, ".done"}, {6'd0, done}, (owner >= 0 && age == TERM + 1) ? eg : 8'd0);
      if (owner >= 0 && age == TERM + 1) dones++;
   endtask
   task automatic tick(input string tag);
      @(posedge clk);
      model_edge(req, pause);
      #2;
      check_all(tag);
   endtask
   task automatic apply_reset(input string tag);
      RST = 1'b0;
      #1;
      owner = -1;
      age = 0;
      cnt_m = 0;
      last_m = 1;
      check_all(tag);
      #1;
      RST = 1'b1;
   endtask
   initial begin
      #1 RST = 1'b0;
      #2 owner = -1;
      check_all("reset");
      #5 RST = 1'b1;
      req = 2'b01;
      for (int i = 0; i < 12; i++) tick("single");
      chk("single.dones", 8'(dones), 8'd1);
      req = 2'b00;
      tick("idle");
      dones = 0;
      req = 2'b11;
      for (int i = 0; i < 3 * (TERM + 3); i++) tick("rr");
      chk("rr.dones", 8'(dones), 8'd3);
      req = 2'b00;
      for (int i = 0; i < 3; i++) tick("rr_drain");
      dones = 0;
      req = 2'b01;
      for (int i = 0; i < 20 && cnt_m != 5; i++) tick("abort_run");
      req = 2'b00;
      for (int i = 0; i < 3; i++) tick("abort");
      chk("abort.count", {4'd0, count}, 8'd5);
      chk("abort.dones", 8'(dones), 8'd0);
      req = 2'b01;
      for (int i = 0; i < 20 && cnt_m != 6; i++) tick("rst_run");
      apply_reset("midrst");
      req = 2'b10;
      for (int i = 0; i < 4; i++) tick("after_rst");
      chk("after_rst.gnt", {6'd0, gnt}, 8'd2);
      req = 2'b00;
      for (int i = 0; i < 2; i++) tick("after_rst_drop");
`ifdef CNT_PAUSE_EN
      req = 2'b01;
      for (int i = 0; i < 20 && cnt_m != 4; i++) tick("pause_run");
      pause = 1'b1;
      for (int i = 0; i < 3; i++) tick("paused");
      chk("paused.count", {4'd0, count}, 8'd4);
      pause = 1'b0;
      for (int i = 0; i < TERM + 2; i++) tick("pause_resume");
      req = 2'b00;
      tick("pause_idle");
`endif
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(15) == 0) req = 2'($urandom_range(3));
`ifdef CNT_PAUSE_EN
         pause = $urandom_range(5) == 0;
`endif
         if ($urandom_range(299) == 0) apply_reset("rand_rst");
         tick("rand");
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/count_arbiter.md
COUNT_ARBITER -- requirements
Module: count_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 4, counter width in bits.
REQ-002 SHALL have parameter: TERM, 9, terminal count value; legal range 1 to 2^WIDTH-1.
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port: RST  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: req  input  2  level requests from requester 0 and requester 1.
REQ-006 SHALL have port: gnt  output  2  one-hot grant; at most one bit high.
REQ-007 SHALL have port: count  output  WIDTH  shared counter value.
REQ-008 SHALL have port: busy  output  1  high when state is RUN or DONE.
REQ-009 SHALL have port: done  output  2  one-cycle completion pulse to the granted requester.
REQ-010 SHALL have port: pause  input  1  freeze request; present only when CNT_PAUSE_EN is defined.

Function
REQ-011 SHALL implement states IDLE, RUN and DONE, encoded as a registered FSM.
REQ-012 IDLE with req nonzero at a rising edge SHALL move to RUN, set gnt to the winner and load count to 0 on that edge.
REQ-013 Arbitration SHALL be round-robin: a single request wins; with both requests, the requester not granted last wins; after reset, requester 0 has priority.
REQ-014 In RUN, count SHALL increment by 1 at each rising edge while count < TERM.
REQ-015 In RUN with count == TERM at a rising edge, the FSM SHALL move to DONE; count holds TERM.
REQ-016 In DONE, done SHALL equal gnt for exactly one cycle; the next edge SHALL return to IDLE, clear gnt and update the last-granted pointer.
REQ-017 Latency from req sampled in IDLE: gnt after edge 1, count==TERM after edge TERM+1, done after edge TERM+2, IDLE after edge TERM+3.
REQ-018 If the granted requester's req is low at a RUN edge, the FSM SHALL abort to IDLE with no done pulse; gnt clears and the pointer still updates.
REQ-019 count SHALL never exceed TERM and never wrap; it holds its last value in IDLE until the next grant loads 0.
REQ-020 A request arriving during RUN or DONE SHALL wait; it is arbitrated only in IDLE, so back-to-back grants are separated by one IDLE cycle.
REQ-021 A req deasserted in DONE SHALL NOT suppress that cycle's done pulse.

Reset
REQ-022 When RST is low, the block SHALL asynchronously force state IDLE, gnt=0, done=0, busy=0, count=0 and the pointer to favour requester 0.
REQ-023 Reset asserted mid-RUN SHALL discard the run with no done pulse; after RST release, the first edge with req nonzero starts a fresh grant.

Configuration
REQ-024 With CNT_PAUSE_EN defined: pause high at a RUN edge SHALL hold count and state; the abort rule REQ-018 still takes priority; pause is ignored in IDLE and DONE.
REQ-025 Without CNT_PAUSE_EN: the pause port SHALL be absent and counting SHALL be uninterrupted.

Verification
REQ-026 Reset, then req=01 held -> gnt=01 after edge 1; count 0..9 over edges 1..10; done=01 for one cycle after edge 11; IDLE after edge 12.
REQ-027 req=11 held continuously -> grants alternate 01,10,01 with one IDLE cycle between runs; each run gives exactly one done pulse to its own requester.
REQ-028 req=01, then req drops to 00 when count=5 -> gnt=00 after the next edge, done never pulses, and count stays 5.
REQ-029 RST driven low when count=6 -> count=0, gnt=0, busy=0 immediately without waiting for a clock edge; a subsequent req=10 grants requester 1 from count 0.
REQ-030 With CNT_PAUSE_EN defined, pause high for 3 edges at count=4 -> count stays 4 and done arrives 3 cycles later than REQ-026; without the macro, the build has no pause port.
